// File: rtl/pipe_reg_chain.sv
// Elastic multi-stage pipeline register: WIDTH-bit data, DEPTH stages, each with
// a valid bit and valid/ready flow control, bubble collapsing and synchronous flush.
module pipe_reg_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH + 1);
    typedef logic [OW-1:0] occ_t;
    localparam occ_t OCC_ONE = occ_t'(1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d   [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] ld;
    logic [WIDTH-1:0] src [DEPTH];
    logic             accept;
    logic             emit;

    // rdy[i] = !v[i] | rdy[i+1], unrolled as "out_ready or some stage at/after i is empty"
    // so the vector never depends on itself.
    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        logic all_full;
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        all_full   = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & v[i];
            rdy[i]   = out_ready | ~all_full;
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign emit      = out_valid & out_ready;

    // Load enable and source for each stage; stage 0 is fed from the input port.
    always_comb begin
        ld     = '0;
        ld[0]  = accept;
        src[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            ld[i]  = v[i-1] & rdy[i];
            src[i] = d[i-1];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // stage samples its neighbour's pre-edge value and the chain shifts by exactly one.
    always_ff @(posedge clk) begin
        if (reset) begin
            v         <= '0;
            occupancy <= '0;
            // NOTE: the data stages are reset because RESET_VAL is visible on out_data;
            // bulk storage would normally be left unreset.
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld[i]) begin
                    d[i] <= src[i];
                    v[i] <= 1'b1;
                end else if (rdy[i+1]) begin
                    v[i] <= 1'b0;
                end
            end
            if (accept && !emit) begin
                occupancy <= occupancy + OCC_ONE;
            end else if (!accept && emit) begin
                occupancy <= occupancy - OCC_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Drives DEPTH=1, 2 and 4 instances with shared stimulus and compares each against
// a token-position reference model of the elastic pipeline.
module tb_pipe_reg_chain;

    localparam int           W  = 32;
    localparam int           NM = 3;
    localparam logic [W-1:0] RV = 32'h0000_005A;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic [NM-1:0] in_ready, out_valid;
    logic [W-1:0] out_data [NM];
    logic [0:0]   occ1;
    logic [1:0]   occ2;
    logic [2:0]   occ4;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(1), .RESET_VAL(RV)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .occupancy(occ1));
    pipe_reg_chain #(.WIDTH(W), .DEPTH(2), .RESET_VAL(RV)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .occupancy(occ2));
    pipe_reg_chain #(.WIDTH(W), .DEPTH(4), .RESET_VAL(RV)) u_d4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_data(out_data[2]), .occupancy(occ4));

    // Reference model: per instance, a list of in-flight tokens (oldest first), each with
    // its data and current position 0..depth-1; last_out is whatever sits at the output.
    int           depth [NM] = '{1, 2, 4};
    int           mn    [NM];
    int           mp    [NM][4];
    logic [W-1:0] md    [NM][4];
    logic [W-1:0] last_out [NM];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Token k advances (or leaves, if at the output) when its next slot is free now
    // or the token ahead of it is itself moving.
    function automatic logic [3:0] moves(input int m);
        logic [3:0] mv;
        mv = '0;
        for (int k = 0; k < mn[m]; k++) begin
            if (k == 0) mv[k] = (mp[m][0] == depth[m] - 1) ? out_ready : 1'b1;
            else        mv[k] = (mp[m][k-1] == mp[m][k] + 1) ? mv[k-1] : 1'b1;
        end
        return mv;
    endfunction

    function automatic logic exp_in_ready(input int m);
        logic [3:0] mv;
        mv = moves(m);
        if (flush)      return 1'b0;
        if (mn[m] == 0) return 1'b1;
        return (mp[m][mn[m]-1] != 0) || mv[mn[m]-1];
    endfunction

    function automatic logic [31:0] occ_of(input int m);
        case (m)
            0:       return 32'(occ1);
            1:       return 32'(occ2);
            default: return 32'(occ4);
        endcase
    endfunction

    task automatic check_all();
        for (int m = 0; m < NM; m++) begin
            logic ov;
            ov = (mn[m] > 0) && (mp[m][0] == depth[m] - 1);
            check($sformatf("d%0d_in_ready", depth[m]), 32'(in_ready[m]), 32'(exp_in_ready(m)));
            check($sformatf("d%0d_out_valid", depth[m]), 32'(out_valid[m]), 32'(ov));
            check($sformatf("d%0d_out_data", depth[m]), out_data[m], last_out[m]);
            check($sformatf("d%0d_occupancy", depth[m]), occ_of(m), 32'(mn[m]));
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < NM; m++) begin
            logic [3:0] mv;
            logic       acc;
            mv  = moves(m);
            acc = in_valid && exp_in_ready(m);
            if (reset) begin
                mn[m]       = 0;
                last_out[m] = RV;
            end else if (flush) begin
                mn[m] = 0;
            end else begin
                for (int k = 0; k < mn[m]; k++) if (mv[k]) mp[m][k]++;
                if (mn[m] > 0 && mp[m][0] == depth[m]) begin
                    for (int k = 1; k < mn[m]; k++) begin
                        mp[m][k-1] = mp[m][k];
                        md[m][k-1] = md[m][k];
                    end
                    mn[m]--;
                end
                if (acc) begin
                    mp[m][mn[m]] = 0;
                    md[m][mn[m]] = in_data;
                    mn[m]++;
                end
                if (mn[m] > 0 && mp[m][0] == depth[m] - 1) last_out[m] = md[m][0];
            end
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                         input logic [W-1:0] dat);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = dat;
    endtask

    // Inputs are set just after a rising edge, outputs compared on the falling edge,
    // and the model advanced on the next rising edge.
    task automatic step(input bit do_chk);
        @(negedge clk);
        if (do_chk) check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        for (int m = 0; m < NM; m++) begin
            mn[m]       = 0;
            last_out[m] = RV;
        end

        // Reset held two cycles with live input traffic.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        step(1'b0);
        step(1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b1);

        // Back-to-back streaming.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, W'(i));
            step(1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        repeat (5) step(1'b1);

        // Backpressure: A, B, C offered with the output stalled, then released.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hA + W'(i));
            step(1'b1);
        end
        step(1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hC);
        step(1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        repeat (6) step(1'b1);

        // Bubble collapse: one word slides to the output stage, then 0x77 joins it.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h66);
        step(1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h77);
        step(1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1);

        // Flush with a word offered in the same cycle; it must never appear.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h99);
        step(1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        repeat (6) step(1'b1);

        // Fill, then full pass-through for four cycles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h100 + W'(i));
            step(1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h200 + W'(i));
            step(1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        repeat (6) step(1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(199) == 0, $urandom_range(39) == 0,
                  $urandom_range(9) < 7, $urandom_range(9) < 6, W'($urandom));
            step(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised elastic pipeline register, WIDTH bits wide and DEPTH stages deep.
- Each stage has a valid bit and a valid/ready handshake. Supports backpressure, bubble collapsing and a synchronous flush.
- Serves as the inter-stage register and decoupling element between datapath blocks of the SimpleRISC core and SoC interconnect. It generalises the single-bit flip-flop into a multi-bit, multi-stage, flow-controlled register.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits, zero-extended).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all stage contents.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  data of stage DEPTH-1.
- occupancy  output  $clog2(DEPTH+1)  registered count of valid stages.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk. Reset has priority over flush and over all transfers.
- State: v[i] and d[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Reset, next edge: all v[i]=0; all d[i]=RESET_VAL; occupancy=0. Hence out_valid=0, out_data=RESET_VAL, and in_ready=1 once reset is deasserted.
- Ready chain (combinational): rdy[DEPTH]=out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0] & !flush.
- Load rule (no reset/flush):
  - Stage 0 loads in_data when in_valid & in_ready.
  - Stage i>0 loads d[i-1] when v[i-1] & rdy[i].
  - On load: d[i] <= source and v[i] <= 1.
  - If stage i is not loaded and its contents move on (rdy[i+1]=1), v[i] <= 0.
  - Otherwise the stage holds.
  - d[i] never changes except on load or reset; bubbles keep stale data.
- Bubble collapsing: a valid stage advances into an empty downstream stage even while out_ready=0.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles from the in_valid handshake cycle to the first cycle out_valid is seen, with no stall.
- Throughput: 1 word/cycle sustained while out_ready=1. Order is strictly preserved. No drop or duplication.
- Full: all v=1 and out_ready=0 gives in_ready=0. All v=1 and out_ready=1 gives in_ready=1, with simultaneous accept and emit; occupancy is unchanged.
- Empty: out_valid=0. out_ready is ignored.
- Flush (reset=0, flush=1):
  - in_ready=0 that cycle; nothing is accepted.
  - The out handshake in the flush cycle still counts as consumed by downstream.
  - Next edge: all v[i]=0 and occupancy=0. d[i] holds.
- occupancy: +1 on accept only, -1 on emit only (out_valid & out_ready), unchanged on both or neither, 0 on flush/reset. Must always equal popcount(v). Never exceeds DEPTH and never underflows.
- Reset or flush mid-stream discards all in-flight words. No partial state survives.
- DEPTH=1: a single stage with in_ready = !v[0] | out_ready (gated by flush).
- in_data is not required to be stable while in_ready=0. Upstream must hold in_valid/in_data until accepted; the block does not check this.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 and in_data=0xDEADBEEF (WIDTH=32, DEPTH=2, RESET_VAL=0x5A) -> out_valid=0, out_data=0x5A, occupancy=0; in_ready=1 after deassertion.
- Streaming: out_ready=1, feed 0x1..0x8 back-to-back -> out_data 0x1..0x8 in order, first out_valid 2 cycles after first accept, one word per cycle, occupancy steady at 2.
- Backpressure: out_ready=0, feed 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 on third, occupancy=2; raise out_ready -> 0xA,0xB,0xC emitted in order with no loss.
- Bubble collapse: fill stage 1 only (occupancy=1), out_ready=0, present 0x77 -> accepted same cycle, occupancy=2.
- Flush: occupancy=2, assert flush 1 cycle with in_valid=1 and in_data=0x99 -> in_ready=0 that cycle; next cycle out_valid=0, occupancy=0; 0x99 never emitted.
- Full pass-through: full, out_ready=1, in_valid=1 for 4 cycles -> accept and emit each cycle, occupancy stays 2. Repeat with DEPTH=1 and DEPTH=4 to check parametrised latency of 1 and 4 cycles.
